// File: rtl/pattern_gen.sv
// pattern_gen: serial bit-pattern transmitter.
// Sends pat_in[len-1:0] MSB-first, one bit per clock, repeated rep_cnt times
// with gap_len idle cycles between repetitions. All outputs are registered.
module pattern_gen #(
    parameter int W  = 5,
    parameter int CW = 8,
    parameter int GW = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [W-1:0]             pat_in,
    input  logic [$clog2(W+1)-1:0]   pat_len,
    input  logic [CW-1:0]            rep_cnt,
    input  logic [GW-1:0]            gap_len,
    output logic                     out_bit,
    output logic                     bit_valid,
    output logic                     frame_start,
    output logic                     busy,
    output logic                     done
);

    localparam int LW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t          state, state_n;
    logic [W-1:0]    pat, pat_n;
    logic [LW-1:0]   len_m1, len_m1_n;
    logic [LW-1:0]   idx, idx_n;
    logic [CW-1:0]   reps_left, reps_n;
    logic [GW-1:0]   gap_cfg, gap_cfg_n;
    logic [GW-1:0]   gap_cnt, gap_n;
    logic            out_bit_n, bit_valid_n, frame_start_n, busy_n, done_n;

    // Launch-time normalisation of length and repetition count.
    logic [LW-1:0]   in_len_m1;
    logic [CW-1:0]   in_reps_m1;

    // Resolve out-of-range length to W and zero repetitions to one.
    always_comb begin
        if (pat_len == '0 || pat_len > LW'(W))
            in_len_m1 = LW'(W - 1);
        else
            in_len_m1 = pat_len - LW'(1);
        if (rep_cnt == '0)
            in_reps_m1 = '0;
        else
            in_reps_m1 = rep_cnt - CW'(1);
    end

    // Next-state and next-output logic; outputs are computed one edge ahead
    // so the registered values line up with the state they describe.
    always_comb begin
        state_n       = state;
        pat_n         = pat;
        len_m1_n      = len_m1;
        idx_n         = idx;
        reps_n        = reps_left;
        gap_cfg_n     = gap_cfg;
        gap_n         = gap_cnt;
        out_bit_n     = 1'b0;
        bit_valid_n   = 1'b0;
        frame_start_n = 1'b0;
        busy_n        = 1'b0;
        done_n        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    pat_n         = pat_in;
                    len_m1_n      = in_len_m1;
                    idx_n         = in_len_m1;
                    reps_n        = in_reps_m1;
                    gap_cfg_n     = gap_len;
                    gap_n         = '0;
                    out_bit_n     = pat_in[in_len_m1];
                    bit_valid_n   = 1'b1;
                    frame_start_n = 1'b1;
                    busy_n        = 1'b1;
                    state_n       = SEND;
                end
            end
            SEND: begin
                if (idx != '0) begin
                    idx_n       = idx - LW'(1);
                    out_bit_n   = pat[idx - LW'(1)];
                    bit_valid_n = 1'b1;
                    busy_n      = 1'b1;
                end else if (reps_left == '0) begin
                    done_n  = 1'b1;
                    state_n = DONE;
                end else if (gap_cfg != '0) begin
                    // gap_cnt holds the gap cycles remaining after this one
                    gap_n   = gap_cfg - GW'(1);
                    busy_n  = 1'b1;
                    state_n = GAP;
                end else begin
                    idx_n         = len_m1;
                    reps_n        = reps_left - CW'(1);
                    out_bit_n     = pat[len_m1];
                    bit_valid_n   = 1'b1;
                    frame_start_n = 1'b1;
                    busy_n        = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt != '0) begin
                    gap_n  = gap_cnt - GW'(1);
                    busy_n = 1'b1;
                end else begin
                    idx_n         = len_m1;
                    reps_n        = reps_left - CW'(1);
                    out_bit_n     = pat[len_m1];
                    bit_valid_n   = 1'b1;
                    frame_start_n = 1'b1;
                    busy_n        = 1'b1;
                    state_n       = SEND;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            pat         <= '0;
            len_m1      <= '0;
            idx         <= '0;
            reps_left   <= '0;
            gap_cfg     <= '0;
            gap_cnt     <= '0;
            out_bit     <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            pat         <= pat_n;
            len_m1      <= len_m1_n;
            idx         <= idx_n;
            reps_left   <= reps_n;
            gap_cfg     <= gap_cfg_n;
            gap_cnt     <= gap_n;
            out_bit     <= out_bit_n;
            bit_valid   <= bit_valid_n;
            frame_start <= frame_start_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: scoreboard bench for pattern_gen.
// Stimulus pushes hand-computed bit streams and done markers into a queue;
// a negedge monitor pops and compares whenever bit_valid or done is seen.
module tb_pattern_gen;

    localparam int W  = 5;
    localparam int CW = 8;
    localparam int GW = 4;
    localparam int LW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  pat_in = '0;
    logic [LW-1:0] pat_len = '0;
    logic [CW-1:0] rep_cnt = '0;
    logic [GW-1:0] gap_len = '0;
    logic          out_bit, bit_valid, frame_start, busy, done;

    always #5 clk = ~clk;

    pattern_gen #(.W(W), .CW(CW), .GW(GW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pat_in      (pat_in),
        .pat_len     (pat_len),
        .rep_cnt     (rep_cnt),
        .gap_len     (gap_len),
        .out_bit     (out_bit),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        bit is_done;
        bit b;
        bit fs;
        int busy_len;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // bits/fsm hold the stream MSB-first: entry n-1 is emitted first.
    task automatic push_burst(input logic [63:0] bits, input logic [63:0] fsm,
                              input int n, input int busy_len, input bit with_done);
        exp_t e;
        for (int i = n - 1; i >= 0; i--) begin
            e.is_done  = 1'b0;
            e.b        = bits[i];
            e.fs       = fsm[i];
            e.busy_len = 0;
            sbq.push_back(e);
        end
        if (with_done) begin
            e.is_done  = 1'b1;
            e.b        = 1'b0;
            e.fs       = 1'b0;
            e.busy_len = busy_len;
            sbq.push_back(e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Inputs are scrambled right after the launch edge to confirm capture.
    task automatic launch(input logic [W-1:0] p, input logic [LW-1:0] l,
                          input logic [CW-1:0] r, input logic [GW-1:0] g);
        pat_in  = p;
        pat_len = l;
        rep_cnt = r;
        gap_len = g;
        start   = 1'b1;
        step(1);
        start   = 1'b0;
        pat_in  = ~p;
        pat_len = ~l;
        rep_cnt = ~r;
        gap_len = ~g;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s timeout: %0d expected entries left, want 0", name, sbq.size());
            sbq.delete();
        end
        step(1);
    endtask

    // Monitor: compares every valid bit and done pulse against the queue.
    initial begin
        bit   prev_valid;
        int   busy_cnt;
        exp_t e;
        prev_valid = 1'b0;
        busy_cnt   = 0;
        forever begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (bit_valid) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_bit: got bit %0d, want no output", out_bit);
                end else begin
                    e = sbq.pop_front();
                    chk("bit_kind", bit_valid & e.is_done, 0);
                    chk("out_bit", out_bit, e.b);
                    chk("frame_start", frame_start, e.fs);
                    chk("busy_with_bit", busy, 1);
                end
            end else begin
                chk("idle_out_bit", out_bit, 0);
                chk("idle_frame_start", frame_start, 0);
            end
            if (done) begin
                chk("done_busy", busy, 0);
                chk("done_after_valid", prev_valid, 1);
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1, want 0");
                end else begin
                    e = sbq.pop_front();
                    chk("done_kind", e.is_done, 1);
                    chk("busy_cycles", busy_cnt, e.busy_len);
                end
                busy_cnt = 0;
            end
            prev_valid = bit_valid;
            if (!rst) busy_cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        step(2);
        chk("rst_out_bit", out_bit, 0);
        chk("rst_bit_valid", bit_valid, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;
        step(1);

        // Single repetition of 10110.
        push_burst(64'b10110, 64'b10000, 5, 5, 1'b1);
        launch(5'b10110, 3'd5, 8'd1, 4'd0);
        wait_drain("t1");

        // Three back-to-back repetitions.
        push_burst(64'b101101011010110, 64'b100001000010000, 15, 15, 1'b1);
        launch(5'b10110, 3'd5, 8'd3, 4'd0);
        wait_drain("t2");

        // Two repetitions with a 3-cycle gap: busy spans 5+3+5.
        push_burst(64'b1011010110, 64'b1000010000, 10, 13, 1'b1);
        launch(5'b10110, 3'd5, 8'd2, 4'd3);
        wait_drain("t3");

        // Length 0 and 7 both mean full width; rep_cnt 0 means once.
        push_burst(64'b11001, 64'b10000, 5, 5, 1'b1);
        launch(5'b11001, 3'd0, 8'd1, 4'd0);
        wait_drain("t4_len0");
        push_burst(64'b00111, 64'b10000, 5, 5, 1'b1);
        launch(5'b00111, 3'd7, 8'd1, 4'd0);
        wait_drain("t4_len7");
        push_burst(64'b10110, 64'b10000, 5, 5, 1'b1);
        launch(5'b10110, 3'd5, 8'd0, 4'd2);
        wait_drain("t4_rep0");
        push_burst(64'b1001, 64'b1000, 4, 4, 1'b1);
        launch(5'b01001, 3'd4, 8'd1, 4'd0);
        wait_drain("t4_len4");

        // start during SEND and DONE is ignored; held into IDLE relaunches.
        push_burst(64'b10110, 64'b10000, 5, 5, 1'b1);
        launch(5'b10110, 3'd5, 8'd1, 4'd0);
        pat_in  = 5'b01001;
        pat_len = 3'd4;
        rep_cnt = 8'd1;
        gap_len = 4'd0;
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        chk("t5_done_cycle", done, 1);
        start = 1'b1;
        push_burst(64'b1001, 64'b1000, 4, 4, 1'b1);
        step(1);
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_valid", bit_valid, 0);
        step(1);
        chk("t5_relaunch_valid", bit_valid, 1);
        chk("t5_relaunch_fs", frame_start, 1);
        chk("t5_relaunch_bit", out_bit, 1);
        start = 1'b0;
        wait_drain("t5");

        // Reset during the 3rd bit of rep 2 (reps=2, gap=2): no done.
        push_burst(64'b10110101, 64'b10000100, 8, 0, 1'b0);
        launch(5'b10110, 3'd5, 8'd2, 4'd2);
        step(9);
        rst = 1'b0;
        step(1);
        chk("t6_out_bit", out_bit, 0);
        chk("t6_bit_valid", bit_valid, 0);
        chk("t6_frame_start", frame_start, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        rst = 1'b1;
        step(1);
        chk("t6_no_late_done", done, 0);
        push_burst(64'b10110, 64'b10000, 5, 5, 1'b1);
        launch(5'b10110, 3'd5, 8'd1, 4'd0);
        chk("t6_restart_bit", out_bit, 1);
        chk("t6_restart_fs", frame_start, 1);
        chk("t6_restart_valid", bit_valid, 1);
        wait_drain("t6");

        step(3);
        chk("queue_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
